bp_host_mmio_ctrl: RTL and testbench
====================================

BP_HOST_MMIO_CTRL -- requirements
Module: bp_host_mmio_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- paddr_width_p, 40, physical address width
- dword_width_p, 64, command/response data width
- num_core_p, 4, cores with a finish slot (1..16)
- num_trace_p, 10, trace/profile enable registers (1..16)
- els_p, 8, command FIFO depth (power of 2, >=2)
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, clock
- reset_n_i, in, 1, asynchronous active-low reset
- io_cmd_addr_i, in, paddr_width_p, command address
- io_cmd_data_i, in, dword_width_p, store data
- io_cmd_wr_i, in, 1, 1=store, 0=load
- io_cmd_v_i, in, 1, command valid
- io_cmd_ready_o, out, 1, FIFO not full
- io_resp_data_o, out, dword_width_p, response data
- io_resp_err_o, out, 1, illegal access
- io_resp_v_o, out, 1, response valid
- io_resp_yumi_i, in, 1, response consumed
- putchar_o, out, 8, output character
- putchar_v_o, out, 1, character valid
- putchar_ready_i, in, 1, sink accepts
- getchar_i, in, 8, input character
- getchar_v_i, in, 1, character available
- getchar_yumi_o, out, 1, character consumed
- trace_en_o, out, num_trace_p, enable bits
- finish_o, out, num_core_p, core has finished
- fail_o, out, num_core_p, core finished with nonzero code
- all_finished_o, out, 1, &finish_o

Function
REQ-003 Command accepted when io_cmd_v_i & io_cmd_ready_o; stored in els_p-deep FIFO; ready_o low only when full.
REQ-004 Address map, exact match, 8-byte slots: getchar 0x0010_0000; putchar 0x0010_1000; finish 0x0010_2000+8*c (c<num_core_p); trace 0x0010_3000+8*t (t<num_trace_p).
REQ-005 Top 3 address bits nonzero, or no map match: io_resp_err_o=1, io_resp_data_o=0, no side effect.
REQ-006 Head-of-FIFO FSM states: IDLE, PUT, RESP.
REQ-007 IDLE, FIFO non-empty: putchar store -> PUT; any other -> perform side effect this cycle, latch response, pop FIFO, -> RESP.
REQ-008 PUT: putchar_v_o=1, putchar_o=data[7:0]; on putchar_ready_i latch response, pop, -> RESP.
REQ-009 RESP: io_resp_v_o=1, data/err held stable; on io_resp_yumi_i -> IDLE. Responses strictly in command order; one response per command.
REQ-010 Getchar load: getchar_v_i=1 -> data = zero-extended getchar_i, getchar_yumi_o pulses 1 cycle; getchar_v_i=0 -> data = all ones, no yumi.
REQ-011 Finish store to slot c: finish_o[c]<=1; fail_o[c]<=data[0]. Only first finish per core counts; later stores to the same slot leave both bits unchanged but still respond.
REQ-012 Trace store to slot t: trace_en_o[t]<=data[0]. Trace load: data = zero-extended trace_en_o[t].
REQ-013 Finish load: data = {fail_o[c], finish_o[c]} zero-extended. Putchar load and getchar store: no side effect, data 0, err 0.
REQ-014 Store response data is 0, err 0.
REQ-015 Side effects occur exactly once, at pop; a command blocked in PUT or RESP has no repeat effect.
REQ-016 Enqueue and pop in the same cycle when full is allowed only if ready_o was high; no overflow, no underflow.
REQ-017 all_finished_o = &finish_o, combinational from registers.

Reset
REQ-018 reset_n_i low asynchronously clears FIFO, FSM->IDLE, trace_en_o, finish_o, fail_o to 0; io_resp_v_o, putchar_v_o, getchar_yumi_o 0; io_cmd_ready_o 0 during reset, 1 the first cycle after release.
REQ-019 Reset asserted mid-PUT or mid-RESP drops the pending command without response or side effect.

Verification
REQ-020 Store 0x41 to 0x0010_1000, putchar_ready_i low 5 cycles then high -> putchar_v_o held 5+ cycles with 0x41, one response data 0, err 0.
REQ-021 Load 0x0010_0000 with getchar_v_i=1, getchar_i=0x7A -> resp 0x7A, one yumi pulse; repeat with getchar_v_i=0 -> resp 0xFFFF_FFFF_FFFF_FFFF.
REQ-022 num_core_p=4: finish stores data 0,1,0,0 to slots 0..3 -> finish_o=4'hF, fail_o=4'h2, all_finished_o=1; second store data 1 to slot 0 -> fail_o stays 4'h2.
REQ-023 Store 1 to 0x0010_3010 then load it -> trace_en_o[2]=1, load data 1; load of 0x0010_3000+8*num_trace_p -> err 1, data 0.
REQ-024 Address with top bits 3'b100 -> err 1, no state change; with io_resp_yumi_i low, push els_p+1 commands -> ready_o low after els_p accepted; responses emerge in order once yumi rises.
REQ-025 Assert reset_n_i mid-RESP -> resp_v_o falls immediately, all registers 0, no response for that command after release.

Source files
------------

// File: rtl/bp_host_mmio_ctrl.sv
// bp_host_mmio_ctrl: host MMIO endpoint with a command FIFO, putchar/getchar, per-core finish and trace enables.
// Rev 1.0
`default_nettype none

module bp_host_mmio_ctrl #(
  parameter int paddr_width_p = 40,
  parameter int dword_width_p = 64,
  parameter int num_core_p    = 4,
  parameter int num_trace_p   = 10,
  parameter int els_p         = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [paddr_width_p-1:0] io_cmd_addr_i,
  input  logic [dword_width_p-1:0] io_cmd_data_i,
  input  logic                     io_cmd_wr_i,
  input  logic                     io_cmd_v_i,
  output logic                     io_cmd_ready_o,
  output logic [dword_width_p-1:0] io_resp_data_o,
  output logic                     io_resp_err_o,
  output logic                     io_resp_v_o,
  input  logic                     io_resp_yumi_i,
  output logic [7:0]               putchar_o,
  output logic                     putchar_v_o,
  input  logic                     putchar_ready_i,
  input  logic [7:0]               getchar_i,
  input  logic                     getchar_v_i,
  output logic                     getchar_yumi_o,
  output logic [num_trace_p-1:0]   trace_en_o,
  output logic [num_core_p-1:0]    finish_o,
  output logic [num_core_p-1:0]    fail_o,
  output logic                     all_finished_o
);

  localparam int ptr_w   = $clog2(els_p);
  localparam int entry_w = paddr_width_p + 8 + 1;

  localparam logic [1:0] idle_s = 2'd0;
  localparam logic [1:0] put_s  = 2'd1;
  localparam logic [1:0] resp_s = 2'd2;

  // Only the low data byte is ever consumed, so the FIFO stores just that.
  logic unused_data_bits;
  assign unused_data_bits = ^io_cmd_data_i[dword_width_p-1:8];

  logic [entry_w-1:0]       mem [els_p];
  logic [ptr_w-1:0]         wr_ptr, rd_ptr;
  logic [ptr_w:0]           count;
  logic [1:0]               state;
  logic                     full, empty, push, pop;
  logic [paddr_width_p-1:0] head_addr;
  logic [7:0]               head_data;
  logic                     head_wr;

  assign full           = (count == (ptr_w+1)'(els_p));
  assign empty          = (count == '0);
  assign io_cmd_ready_o = reset_n_i & ~full;
  assign push           = io_cmd_v_i & io_cmd_ready_o;
  assign {head_addr, head_data, head_wr} = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {io_cmd_addr_i, io_cmd_data_i[7:0], io_cmd_wr_i};
  end

  // Address decode of the FIFO head
  logic [paddr_width_p-13:0] page;
  logic [8:0]                slot;
  logic                      aligned, hit_get, hit_put, fin_page, tr_page;
  logic [num_core_p-1:0]     fin_sel;
  logic [num_trace_p-1:0]    tr_sel;
  logic                      fin_any, tr_any, map_hit, fin_bit, fail_bit, tr_bit;

  assign page     = head_addr[paddr_width_p-1:12];
  assign slot     = head_addr[11:3];
  assign aligned  = (head_addr[2:0] == 3'b000);
  assign hit_get  = (head_addr == paddr_width_p'(32'h0010_0000));
  assign hit_put  = (head_addr == paddr_width_p'(32'h0010_1000));
  assign fin_page = aligned && (page == (paddr_width_p-12)'(32'h102));
  assign tr_page  = aligned && (page == (paddr_width_p-12)'(32'h103));

  always_comb begin
    fin_sel = '0;
    tr_sel  = '0;
    for (int c = 0; c < num_core_p; c++) fin_sel[c] = fin_page && (slot == 9'(c));
    for (int t = 0; t < num_trace_p; t++) tr_sel[t] = tr_page && (slot == 9'(t));
  end

  assign fin_any  = |fin_sel;
  assign tr_any   = |tr_sel;
  assign map_hit  = hit_get | hit_put | fin_any | tr_any;
  assign fin_bit  = |(fin_sel & finish_o);
  assign fail_bit = |(fin_sel & fail_o);
  assign tr_bit   = |(tr_sel & trace_en_o);

  logic [dword_width_p-1:0] resp_data_n;
  logic                     resp_err_n;

  always_comb begin
    resp_data_n = '0;
    resp_err_n  = 1'b0;
    if (!map_hit) begin
      resp_err_n = 1'b1;
    end else if (!head_wr) begin
      if (hit_get)      resp_data_n = getchar_v_i ? dword_width_p'(getchar_i) : '1;
      else if (fin_any) resp_data_n = dword_width_p'({fail_bit, fin_bit});
      else if (tr_any)  resp_data_n = dword_width_p'(tr_bit);
    end
  end

  logic exec, put_done;
  assign exec     = (state == idle_s) && !empty && !(hit_put && head_wr);
  assign put_done = (state == put_s) && putchar_ready_i;
  assign pop      = exec | put_done;

  assign getchar_yumi_o = exec && hit_get && !head_wr && getchar_v_i;
  assign putchar_v_o    = (state == put_s);
  assign putchar_o      = head_data;
  assign io_resp_v_o    = (state == resp_s);
  assign all_finished_o = &finish_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= idle_s;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      io_resp_data_o <= '0;
      io_resp_err_o  <= 1'b0;
      trace_en_o     <= '0;
      finish_o       <= '0;
      fail_o         <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
      case ({push, pop})
        2'b10:   count <= count + (ptr_w+1)'(1);
        2'b01:   count <= count - (ptr_w+1)'(1);
        default: count <= count;
      endcase

      case (state)
        idle_s: if (!empty) state <= (hit_put && head_wr) ? put_s : resp_s;
        put_s:  if (putchar_ready_i) state <= resp_s;
        resp_s: if (io_resp_yumi_i) state <= idle_s;
        default: state <= idle_s;
      endcase

      if (pop) begin
        io_resp_data_o <= resp_data_n;
        io_resp_err_o  <= resp_err_n;
      end

      // Side effects happen once, when the command leaves the FIFO
      if (exec && head_wr) begin
        for (int c = 0; c < num_core_p; c++) begin
          if (fin_sel[c] && !finish_o[c]) begin
            finish_o[c] <= 1'b1;
            fail_o[c]   <= head_data[0];
          end
        end
        for (int t = 0; t < num_trace_p; t++) begin
          if (tr_sel[t]) trace_en_o[t] <= head_data[0];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bp_host_mmio_ctrl.sv
// tb_bp_host_mmio_ctrl: directed stimulus with a response scoreboard for bp_host_mmio_ctrl.
// Rev 1.0
`default_nettype none

module tb_bp_host_mmio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [39:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        cmd_wr = 1'b0;
  logic        cmd_v = 1'b0;
  logic        cmd_ready;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        resp_v;
  logic        resp_yumi = 1'b1;
  logic [7:0]  putchar;
  logic        putchar_v;
  logic        putchar_ready = 1'b1;
  logic [7:0]  getchar = '0;
  logic        getchar_v = 1'b0;
  logic        getchar_yumi;
  logic [9:0]  trace_en;
  logic [3:0]  finish;
  logic [3:0]  fail;
  logic        all_finished;

  int checks = 0;
  int failures = 0;
  int sent = 0;
  int resp_cnt = 0;
  int yumi_cnt = 0;
  logic [64:0] exp_q [$];

  localparam logic [39:0] get_a = 40'h00_0010_0000;
  localparam logic [39:0] put_a = 40'h00_0010_1000;
  localparam logic [39:0] fin_a = 40'h00_0010_2000;
  localparam logic [39:0] tr_a  = 40'h00_0010_3000;
  localparam logic [63:0] ones  = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  bp_host_mmio_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .io_cmd_addr_i(cmd_addr), .io_cmd_data_i(cmd_data), .io_cmd_wr_i(cmd_wr),
    .io_cmd_v_i(cmd_v), .io_cmd_ready_o(cmd_ready),
    .io_resp_data_o(resp_data), .io_resp_err_o(resp_err), .io_resp_v_o(resp_v),
    .io_resp_yumi_i(resp_yumi),
    .putchar_o(putchar), .putchar_v_o(putchar_v), .putchar_ready_i(putchar_ready),
    .getchar_i(getchar), .getchar_v_i(getchar_v), .getchar_yumi_o(getchar_yumi),
    .trace_en_o(trace_en), .finish_o(finish), .fail_o(fail), .all_finished_o(all_finished)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every accepted response against the queue head.
  always @(negedge clk) begin
    if (reset_n && resp_v && resp_yumi) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%h/%b required=none", resp_data, resp_err);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("resp_err", 64'(resp_err), 64'(e[64]));
        check("resp_data", resp_data, e[63:0]);
      end
    end
    if (getchar_yumi) yumi_cnt++;
  end

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input logic [39:0] a, input logic [63:0] d, input logic w,
                      input logic [63:0] ed, input logic ee);
    int t = 0;
    cmd_addr = a; cmd_data = d; cmd_wr = w; cmd_v = 1'b1;
    while (!cmd_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    exp_q.push_back({ee, ed});
    sent++;
    @(posedge clk); #1;
    cmd_v = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); t++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(cmd_ready), 0);
    check("rst_resp_v", 64'(resp_v), 0);
    check("rst_putchar_v", 64'(putchar_v), 0);
    check("rst_getchar_yumi", 64'(getchar_yumi), 0);
    check("rst_state_regs", {44'd0, trace_en, finish, fail, 1'b0, all_finished}, 0);
    @(negedge clk); reset_n = 1'b1;
    #1 check("ready_after_rst", 64'(cmd_ready), 1);
    @(posedge clk); #1;

    // Putchar with a stalled sink
    putchar_ready = 1'b0;
    send(put_a, 64'h41, 1'b1, 64'd0, 1'b0);
    t = 0;
    @(negedge clk);
    while (!putchar_v && t < 50) begin @(negedge clk); t++; end
    for (int i = 0; i < 5; i++) begin
      check("putchar_v_held", 64'(putchar_v), 1);
      check("putchar_data", 64'(putchar), 64'h41);
      @(negedge clk);
    end
    check("resp_v_during_put", 64'(resp_v), 0);
    putchar_ready = 1'b1;
    drain();

    // Getchar with and without a character available
    getchar_v = 1'b1; getchar = 8'h7A;
    send(get_a, 64'd0, 1'b0, 64'h7A, 1'b0);
    drain();
    check("getchar_yumi_once", 64'(yumi_cnt), 1);
    getchar_v = 1'b0;
    send(get_a, 64'd0, 1'b0, ones, 1'b0);
    drain();
    check("getchar_no_yumi", 64'(yumi_cnt), 1);

    // Illegal addresses leave finish state untouched
    send(40'h80_0010_2000, 64'd1, 1'b1, 64'd0, 1'b1);
    send(40'h00_0010_2004, 64'd1, 1'b1, 64'd0, 1'b1);
    drain();
    check("bad_addr_finish", 64'(finish), 0);
    check("bad_addr_fail", 64'(fail), 0);

    // Finish slots
    send(fin_a + 40'd0,  64'd0, 1'b1, 64'd0, 1'b0);
    send(fin_a + 40'd8,  64'd1, 1'b1, 64'd0, 1'b0);
    send(fin_a + 40'd16, 64'd0, 1'b1, 64'd0, 1'b0);
    send(fin_a + 40'd24, 64'd0, 1'b1, 64'd0, 1'b0);
    drain();
    check("finish_all", 64'(finish), 64'hF);
    check("fail_mask", 64'(fail), 64'h2);
    check("all_finished", 64'(all_finished), 1);
    send(fin_a, 64'd1, 1'b1, 64'd0, 1'b0);
    send(fin_a + 40'd8, 64'd0, 1'b0, 64'd3, 1'b0);
    send(fin_a, 64'd0, 1'b0, 64'd1, 1'b0);
    drain();
    check("fail_sticky", 64'(fail), 64'h2);
    check("finish_sticky", 64'(finish), 64'hF);

    // Trace registers and the remaining no-effect accesses
    send(tr_a + 40'h10, 64'd1, 1'b1, 64'd0, 1'b0);
    send(tr_a + 40'h10, 64'd0, 1'b0, 64'd1, 1'b0);
    send(tr_a + 40'h50, 64'd0, 1'b0, 64'd0, 1'b1);
    send(put_a, 64'd0, 1'b0, 64'd0, 1'b0);
    send(get_a, 64'd5, 1'b1, 64'd0, 1'b0);
    drain();
    check("trace_en", 64'(trace_en), 64'h004);
    check("getchar_store_no_yumi", 64'(yumi_cnt), 1);

    // Backpressure: one command parks in RESP, els_p more fill the FIFO
    resp_yumi = 1'b0;
    send(tr_a + 40'h18, 64'd1, 1'b1, 64'd0, 1'b0);
    send(tr_a + 40'h18, 64'd0, 1'b0, 64'd1, 1'b0);
    send(fin_a + 40'd8, 64'd0, 1'b0, 64'd3, 1'b0);
    send(40'h00_0010_4000, 64'd0, 1'b0, 64'd0, 1'b1);
    send(tr_a + 40'h18, 64'd0, 1'b1, 64'd0, 1'b0);
    send(tr_a + 40'h18, 64'd0, 1'b0, 64'd0, 1'b0);
    send(get_a, 64'd0, 1'b0, ones, 1'b0);
    send(fin_a, 64'd0, 1'b0, 64'd1, 1'b0);
    send(tr_a + 40'h10, 64'd0, 1'b0, 64'd1, 1'b0);
    check("full_ready_low", 64'(cmd_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check("full_ready_still_low", 64'(cmd_ready), 0);
    check("full_resp_v", 64'(resp_v), 1);
    resp_yumi = 1'b1;
    send(tr_a + 40'h18, 64'd0, 1'b0, 64'd0, 1'b0);
    drain();
    check("trace_after_burst", 64'(trace_en), 64'h004);

    // Reset while a response is pending
    resp_yumi = 1'b0;
    send(tr_a + 40'h28, 64'd1, 1'b1, 64'd0, 1'b0);
    t = 0;
    @(negedge clk);
    while (!resp_v && t < 50) begin @(negedge clk); t++; end
    check("pre_rst_resp_v", 64'(resp_v), 1);
    check("pre_rst_trace", 64'(trace_en), 64'h024);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_resp_v", 64'(resp_v), 0);
    check("midrst_regs", {44'd0, trace_en, finish, fail, 1'b0, all_finished}, 0);
    check("midrst_ready", 64'(cmd_ready), 0);
    void'(exp_q.pop_front());
    sent--;
    resp_yumi = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    #1 check("post_rst_ready", 64'(cmd_ready), 1);
    repeat (10) @(posedge clk);
    #1;
    send(tr_a + 40'h28, 64'd0, 1'b0, 64'd0, 1'b0);
    drain();
    check("resp_count", 64'(resp_cnt), 64'(sent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
